// File: rtl/tx_slot_scheduler.sv
// tx_slot_scheduler: TDMA symbol/slot/frame time base, payload bit FIFO and burst sequencer
// feeding the GMSK burst transmitter (fire_burst / is_armed / bit_request interface).
// Optional feature macro: TX_SCHED_PRBS_FILL_EN -- fire under-filled enabled slots with
// LFSR fill bits instead of counting them as missed.
module tx_slot_scheduler #(
    parameter int SYMBOLS_PER_SLOT = 156,
    parameter int SLOTS_PER_FRAME  = 8,
    parameter int BURST_BITS       = 148,
    parameter int FIFO_DEPTH       = 256,
    parameter int FN_BITS          = 16
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       symbol_strobe,
    input  logic [SLOTS_PER_FRAME-1:0] slot_enable,
    input  logic                       payload_bit,
    input  logic                       payload_valid,
    output logic                       payload_ready,
    input  logic                       is_armed,
    output logic                       fire_burst,
    input  logic                       bit_request,
    output logic                       burst_bit,
    output logic [2:0]                 slot_number,
    output logic [FN_BITS-1:0]         frame_number,
    output logic                       busy,
    output logic [7:0]                 missed_slots
);
    localparam int SYM_W = $clog2(SYMBOLS_PER_SLOT);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int BL_W  = $clog2(BURST_BITS + 1);
    localparam logic [SYM_W-1:0] SYM_LAST  = SYM_W'(SYMBOLS_PER_SLOT - 1);
    localparam logic [2:0]       SLOT_LAST = 3'(SLOTS_PER_FRAME - 1);
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_BURST = CNT_W'(BURST_BITS);
    localparam logic [BL_W-1:0]  BL_LOAD   = BL_W'(BURST_BITS);
    localparam logic [BL_W-1:0]  BL_LAST   = BL_W'(1);

    typedef enum logic [1:0] {IDLE, FIRE, STREAM} state_t;

    state_t             state, state_next;
    logic [SYM_W-1:0]   sym_cnt;
    logic [2:0]         next_slot;
    logic               slot_start;
    logic               slot_on;
    logic               fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [CNT_W-1:0]   count;
    logic [BL_W-1:0]    bits_left;
    logic               stream_req;
    logic               stream_bit;
    logic               push, pop;
    logic               miss;
`ifdef TX_SCHED_PRBS_FILL_EN
    logic               fill_start;
    logic               fill_mode;
    logic [7:0]         lfsr;
`endif

    assign slot_start    = symbol_strobe && (sym_cnt == SYM_LAST);
    assign next_slot     = (slot_number == SLOT_LAST) ? 3'd0 : slot_number + 3'd1;
    assign slot_on       = slot_enable[next_slot];
    assign payload_ready = count < CNT_FULL;
    assign busy          = state != IDLE;
    assign stream_req    = (state == STREAM) && bit_request;
`ifdef TX_SCHED_PRBS_FILL_EN
    assign pop           = stream_req && !fill_mode;
    assign stream_bit    = fill_mode ? lfsr[1] : fifo_mem[rd_ptr];
`else
    assign pop           = stream_req;
    assign stream_bit    = fifo_mem[rd_ptr];
`endif
    // A pop in the same cycle frees the slot the push lands in, so a full FIFO still takes it.
    assign push          = payload_valid && (payload_ready || pop);

    // Symbol counter with slot and frame rollover at each slot start.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sym_cnt      <= '0;
            slot_number  <= '0;
            frame_number <= '0;
        end else if (symbol_strobe) begin
            sym_cnt <= slot_start ? '0 : sym_cnt + 1'b1;
            if (slot_start) begin
                slot_number <= next_slot;
                if (slot_number == SLOT_LAST)
                    frame_number <= frame_number + 1'b1;
            end
        end
    end

    // Payload bit storage; contents are don't-care once the pointers are reset.
    always_ff @(posedge clock) begin
        if (push)
            fifo_mem[wr_ptr] <= payload_bit;
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Burst FSM state register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Slot decision, burst sequencing and missed-slot detection.
    always_comb begin
        state_next = state;
        fire_burst = 1'b0;
        miss       = slot_start && slot_on && (state != IDLE);
`ifdef TX_SCHED_PRBS_FILL_EN
        fill_start = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (slot_start && slot_on) begin
                    if (is_armed && count >= CNT_BURST)
                        state_next = FIRE;
`ifdef TX_SCHED_PRBS_FILL_EN
                    else if (is_armed) begin
                        state_next = FIRE;
                        fill_start = 1'b1;
                    end
`endif
                    else
                        miss = 1'b1;
                end
            end
            FIRE: begin
                fire_burst = 1'b1;
                state_next = STREAM;
            end
            STREAM: begin
                if (bit_request && bits_left == BL_LAST)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Bits remaining in the burst being streamed.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            bits_left <= '0;
        else if (state == FIRE)
            bits_left <= BL_LOAD;
        else if (stream_req)
            bits_left <= bits_left - 1'b1;
    end

    // Registered symbol to the transmitter; idle ones outside a burst.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            burst_bit <= 1'b1;
        else if (bit_request)
            burst_bit <= stream_req ? stream_bit : 1'b1;
    end

    // Saturating count of enabled slots that produced no burst.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            missed_slots <= '0;
        else if (miss && missed_slots != 8'hff)
            missed_slots <= missed_slots + 1'b1;
    end

`ifdef TX_SCHED_PRBS_FILL_EN
    // Fill-burst LFSR: reseeded at each fill burst, advanced once per streamed bit.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            lfsr      <= 8'h01;
            fill_mode <= 1'b0;
        end else if (fill_start) begin
            lfsr      <= 8'h01;
            fill_mode <= 1'b1;
        end else begin
            if (stream_req && fill_mode)
                lfsr <= {1'b0, lfsr[7:1]} ^ (lfsr[0] ? 8'h8e : 8'h00);
            if (state == STREAM && state_next == IDLE)
                fill_mode <= 1'b0;
        end
    end
`endif

endmodule
